// File: rtl/bcd_timer_counter_if.sv
// Control and status bundle for the BCD timer counter.
// The master side issues tick/control requests and load data; the slave side
// (the counter) returns the BCD count, FSM state and status pulses.
interface bcd_timer_counter_if #(
    parameter int DIGITS = 2
);
    logic                  tick;
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  dir;
    logic                  auto_reload;
    logic [4*DIGITS-1:0]   count;
    logic [1:0]            state;
    logic                  running;
    logic                  done;
    logic                  load_err;

    modport master (
        output tick, start, stop, clear, load, load_val, dir, auto_reload,
        input  count, state, running, done, load_err
    );

    modport slave (
        input  tick, start, stop, clear, load, load_val, dir, auto_reload,
        output count, state, running, done, load_err
    );
endinterface

// File: rtl/bcd_timer_counter.sv
// Multi-digit BCD up/down timer counter with run/pause/done control.
// Counts qualifying ticks between 0 and MAX_VAL, with either wrap-around
// (auto reload) or stop-at-terminal behaviour, and a range-checked BCD load.
module bcd_timer_counter #(
    parameter int DIGITS  = 2,
    parameter int MAX_VAL = 99
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_timer_counter_if.slave   bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Elaboration-time conversion of a decimal integer to packed BCD.
    function automatic logic [W-1:0] to_bcd(input int value);
        int            v;
        logic [W-1:0]  r;
        v = value;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // True when every nibble holds a decimal digit.
    function automatic logic bcd_ok(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // BCD increment: 9 rolls to 0 and carries into the next digit.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD decrement: 0 rolls to 9 and borrows from the next digit.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // With every digit valid, unsigned compare of packed BCD matches the
    // decimal ordering, so the range check needs no binary conversion.
    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

    state_t        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic          done_q, done_d;
    logic          load_err_q, load_err_d;

    logic          load_ok;
    logic          start_ok;
    logic          terminal;

    assign load_ok  = bcd_ok(bus.load_val) && (bus.load_val <= MAX_BCD);
    assign start_ok = (state_q == IDLE) || (state_q == PAUSE);
    assign terminal = bus.dir ? (count_q == MAX_BCD) : (count_q == '0);

    // State, count and status pulse registers; reset returns everything to IDLE/0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    // Next-state/count decode in priority order clear > load > stop > start > tick.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;

        if (bus.clear) begin
            count_d = '0;
            state_d = IDLE;
        end else if (bus.load) begin
            if (load_ok) begin
                count_d = bus.load_val;
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.stop) begin
            // stop beats a simultaneous start; it only has effect from RUN/PAUSE
            if ((state_q == RUN) || (state_q == PAUSE)) begin
                state_d = PAUSE;
            end
        end else if (bus.start && start_ok) begin
            state_d = RUN;
        end else if (bus.tick && (state_q == RUN)) begin
            if (terminal) begin
                done_d = 1'b1;
                if (bus.auto_reload) begin
                    count_d = bus.dir ? '0 : MAX_BCD;
                end else begin
                    state_d = DONE;
                end
            end else begin
                count_d = bus.dir ? bcd_inc(count_q) : bcd_dec(count_q);
            end
        end
    end

    assign bus.count    = count_q;
    assign bus.state    = state_q;
    assign bus.running  = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_timer_counter.sv
// Directed bench for bcd_timer_counter: a table of single-cycle vectors on a
// two-digit (MAX 99) instance plus hand-written multi-cycle sequences, and a
// three-digit (MAX 359) instance for the non-default configuration.
module tb_bcd_timer_counter;
    logic clk;
    logic rst2;
    logic rst3;

    int errors;
    int checks;

    bcd_timer_counter_if #(.DIGITS(2)) if2 ();
    bcd_timer_counter_if #(.DIGITS(3)) if3 ();

    bcd_timer_counter #(.DIGITS(2), .MAX_VAL(99)) u2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (if2.slave)
    );

    bcd_timer_counter #(.DIGITS(3), .MAX_VAL(359)) u3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, clr, ld;
        logic [7:0] lv;
        logic       st, sp, tk, dr, ar;
        logic [7:0] cnt;
        logic [1:0] stt;
        logic       dn, le;
    } vec_t;

    vec_t tbl[$];

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

    function automatic void v(input logic rst, input logic clr, input logic ld,
                              input logic [7:0] lv, input logic st, input logic sp,
                              input logic tk, input logic dr, input logic ar,
                              input logic [7:0] cnt, input logic [1:0] stt,
                              input logic dn, input logic le);
        vec_t e;
        e.rst = rst; e.clr = clr; e.ld = ld; e.lv = lv; e.st = st; e.sp = sp;
        e.tk = tk; e.dr = dr; e.ar = ar; e.cnt = cnt; e.stt = stt; e.dn = dn; e.le = le;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs to the 2-digit instance; return just after the edge.
    task automatic cyc2(input logic rst, input logic clr, input logic ld, input logic [7:0] lv,
                        input logic st, input logic sp, input logic tk, input logic dr,
                        input logic ar);
        rst2 = rst; if2.clear = clr; if2.load = ld; if2.load_val = lv;
        if2.start = st; if2.stop = sp; if2.tick = tk; if2.dir = dr; if2.auto_reload = ar;
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs to the 3-digit instance; return just after the edge.
    task automatic cyc3(input logic rst, input logic clr, input logic ld, input logic [11:0] lv,
                        input logic st, input logic sp, input logic tk, input logic dr,
                        input logic ar);
        rst3 = rst; if3.clear = clr; if3.load = ld; if3.load_val = lv;
        if3.start = st; if3.stop = sp; if3.tick = tk; if3.dir = dr; if3.auto_reload = ar;
        @(posedge clk);
        #1;
    endtask

    task automatic chk2(input string tag, input logic [7:0] cnt, input logic [1:0] stt,
                        input logic dn, input logic le);
        chk({tag, " count"},    32'(if2.count),    32'(cnt));
        chk({tag, " state"},    32'(if2.state),    32'(stt));
        chk({tag, " done"},     32'(if2.done),     32'(dn));
        chk({tag, " load_err"}, 32'(if2.load_err), 32'(le));
        chk({tag, " running"},  32'(if2.running),  32'(stt == S_RUN));
    endtask

    task automatic chk3(input string tag, input logic [11:0] cnt, input logic [1:0] stt,
                        input logic dn, input logic le);
        chk({tag, " count"},    32'(if3.count),    32'(cnt));
        chk({tag, " state"},    32'(if3.state),    32'(stt));
        chk({tag, " done"},     32'(if3.done),     32'(dn));
        chk({tag, " load_err"}, 32'(if3.load_err), 32'(le));
        chk({tag, " running"},  32'(if3.running),  32'(stt == S_RUN));
    endtask

    initial begin
        int m;
        int dones;
        logic [7:0] eb;

        errors = 0;
        checks = 0;
        cyc2(1, 0, 0, 8'h00, 0, 0, 0, 1, 1);
        cyc3(1, 0, 0, 12'h000, 0, 0, 0, 1, 1);

        //  rst clr ld  lv    st sp tk dr ar   cnt    state    dn le
        v(1, 0, 0, 8'h00, 0, 0, 0, 1, 1,   8'h00, S_IDLE,  0, 0); // reset
        v(0, 0, 0, 8'h00, 0, 0, 1, 1, 1,   8'h00, S_IDLE,  0, 0); // tick in IDLE ignored
        v(0, 0, 0, 8'h00, 1, 0, 0, 1, 1,   8'h00, S_RUN,   0, 0); // start
        v(0, 0, 0, 8'h00, 0, 0, 1, 1, 1,   8'h01, S_RUN,   0, 0);
        v(0, 0, 0, 8'h00, 0, 0, 1, 1, 1,   8'h02, S_RUN,   0, 0);
        v(0, 0, 0, 8'h00, 0, 0, 1, 0, 1,   8'h01, S_RUN,   0, 0); // down
        v(0, 0, 0, 8'h00, 0, 1, 1, 1, 1,   8'h01, S_PAUSE, 0, 0); // stop+tick
        v(0, 0, 0, 8'h00, 0, 0, 1, 1, 1,   8'h01, S_PAUSE, 0, 0); // tick in PAUSE
        v(0, 0, 0, 8'h00, 1, 1, 0, 1, 1,   8'h01, S_PAUSE, 0, 0); // start+stop
        v(0, 0, 0, 8'h00, 1, 0, 1, 1, 1,   8'h01, S_RUN,   0, 0); // start+tick
        v(0, 0, 0, 8'h00, 0, 0, 1, 1, 1,   8'h02, S_RUN,   0, 0);
        v(0, 1, 1, 8'h42, 0, 0, 0, 1, 1,   8'h00, S_IDLE,  0, 0); // clear beats load
        v(0, 0, 1, 8'h42, 0, 0, 0, 1, 1,   8'h42, S_IDLE,  0, 0);
        v(0, 0, 1, 8'h3A, 0, 0, 0, 1, 1,   8'h42, S_IDLE,  0, 1); // non-BCD digit
        v(0, 0, 1, 8'h99, 0, 0, 0, 1, 1,   8'h99, S_IDLE,  0, 0); // MAX accepted
        v(0, 0, 0, 8'h00, 1, 0, 0, 1, 1,   8'h99, S_RUN,   0, 0);
        v(0, 0, 0, 8'h00, 0, 0, 1, 0, 0,   8'h98, S_RUN,   0, 0); // reversal at MAX
        v(0, 0, 1, 8'h99, 0, 0, 0, 1, 0,   8'h99, S_RUN,   0, 0); // load in RUN
        v(0, 0, 0, 8'h00, 0, 0, 1, 1, 0,   8'h99, S_DONE,  1, 0); // terminal, stop mode
        v(0, 0, 0, 8'h00, 0, 0, 1, 1, 0,   8'h99, S_DONE,  0, 0);
        v(0, 0, 0, 8'h00, 1, 0, 0, 1, 0,   8'h99, S_DONE,  0, 0); // start ignored
        v(0, 0, 0, 8'h00, 0, 1, 0, 1, 0,   8'h99, S_DONE,  0, 0); // stop ignored
        v(0, 0, 1, 8'h42, 0, 0, 0, 1, 0,   8'h42, S_IDLE,  0, 0); // load leaves DONE
        v(0, 0, 0, 8'h00, 1, 0, 0, 1, 1,   8'h42, S_RUN,   0, 0);
        v(0, 0, 1, 8'h37, 0, 0, 0, 1, 1,   8'h37, S_RUN,   0, 0);
        v(1, 0, 0, 8'h00, 0, 0, 1, 1, 1,   8'h00, S_IDLE,  0, 0); // reset mid-RUN
        v(0, 0, 0, 8'h00, 0, 0, 1, 1, 1,   8'h00, S_IDLE,  0, 0);
        v(0, 0, 0, 8'h00, 1, 0, 0, 1, 1,   8'h00, S_RUN,   0, 0);
        v(0, 0, 0, 8'h00, 0, 0, 1, 0, 1,   8'h99, S_RUN,   1, 0); // down wrap to MAX
        v(0, 0, 0, 8'h00, 0, 0, 1, 0, 1,   8'h98, S_RUN,   0, 0);
        v(0, 0, 1, 8'h09, 0, 0, 0, 1, 1,   8'h09, S_RUN,   0, 0);
        v(0, 0, 0, 8'h00, 0, 0, 1, 1, 1,   8'h10, S_RUN,   0, 0); // carry
        v(0, 0, 0, 8'h00, 0, 0, 1, 0, 1,   8'h09, S_RUN,   0, 0); // borrow
        v(0, 1, 0, 8'h00, 0, 0, 1, 1, 1,   8'h00, S_IDLE,  0, 0); // clear

        foreach (tbl[i]) begin
            cyc2(tbl[i].rst, tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].sp,
                 tbl[i].tk, tbl[i].dr, tbl[i].ar);
            chk2($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].stt, tbl[i].dn, tbl[i].le);
        end

        // Up-count with wrap through a full 100-tick cycle.
        cyc2(1, 0, 0, 8'h00, 0, 0, 0, 1, 1);
        cyc2(0, 0, 0, 8'h00, 1, 0, 0, 1, 1);
        m = 0;
        dones = 0;
        for (int k = 1; k <= 100; k++) begin
            cyc2(0, 0, 0, 8'h00, 0, 0, 1, 1, 1);
            m  = (m + 1) % 100;
            eb = {4'(m / 10), 4'(m % 10)};
            chk($sformatf("wrap%0d count", k), 32'(if2.count), 32'(eb));
            chk($sformatf("wrap%0d done", k), 32'(if2.done), 32'(k == 100));
            if (if2.done) dones++;
        end
        chk("wrap done pulses", 32'(dones), 32'd1);
        chk("wrap state", 32'(if2.state), 32'(S_RUN));

        // Down-count to zero in stop mode.
        cyc2(1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        cyc2(0, 0, 1, 8'h05, 0, 0, 0, 0, 0);
        chk2("dn load", 8'h05, S_IDLE, 0, 0);
        cyc2(0, 0, 0, 8'h00, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            cyc2(0, 0, 0, 8'h00, 0, 0, 1, 0, 0);
            chk2($sformatf("dn%0d", k), (k <= 5) ? 8'(5 - k) : 8'h00,
                 (k == 6) ? S_DONE : S_RUN, k == 6, 0);
        end
        for (int k = 0; k < 2; k++) begin
            cyc2(0, 0, 0, 8'h00, 0, 0, 1, 0, 0);
            chk2($sformatf("dn_hold%0d", k), 8'h00, S_DONE, 0, 0);
        end
        cyc2(0, 0, 0, 8'h00, 0, 0, 0, 1, 1);

        // Three-digit instance with MAX 359.
        cyc3(1, 0, 0, 12'h000, 0, 0, 0, 1, 1);
        chk3("d3 reset", 12'h000, S_IDLE, 0, 0);
        cyc3(0, 0, 1, 12'h359, 0, 0, 0, 1, 1);
        chk3("d3 load359", 12'h359, S_IDLE, 0, 0);
        cyc3(0, 0, 0, 12'h000, 1, 0, 0, 1, 1);
        cyc3(0, 0, 0, 12'h000, 0, 0, 1, 1, 1);
        chk3("d3 wrap", 12'h000, S_RUN, 1, 0);
        cyc3(0, 0, 1, 12'h360, 0, 0, 0, 1, 1);
        chk3("d3 load360", 12'h000, S_RUN, 0, 1);
        cyc3(0, 0, 1, 12'h1A0, 0, 0, 0, 1, 1);
        chk3("d3 load1A0", 12'h000, S_RUN, 0, 1);
        cyc3(0, 0, 0, 12'h000, 0, 0, 0, 1, 1);
        chk3("d3 err clear", 12'h000, S_RUN, 0, 0);
        cyc3(0, 0, 1, 12'h199, 0, 0, 0, 1, 1);
        cyc3(0, 0, 0, 12'h000, 0, 0, 1, 1, 1);
        chk3("d3 199up", 12'h200, S_RUN, 0, 0);
        cyc3(0, 0, 0, 12'h000, 0, 0, 1, 0, 1);
        chk3("d3 200dn", 12'h199, S_RUN, 0, 0);
        cyc3(0, 0, 1, 12'h100, 0, 0, 0, 0, 1);
        cyc3(0, 0, 0, 12'h000, 0, 0, 1, 0, 1);
        chk3("d3 100dn", 12'h099, S_RUN, 0, 0);
        cyc3(0, 0, 1, 12'h000, 0, 0, 0, 0, 1);
        cyc3(0, 0, 0, 12'h000, 0, 0, 1, 0, 1);
        chk3("d3 0dn", 12'h359, S_RUN, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
